// File: rtl/aes192_pkg.sv
// Shared AES-192 key-schedule constants, word/state types and GF(2^8) doubling.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes192_pkg;

    localparam int NK = 6;
    localparam int NR = 12;
    localparam int NW = 4 * (NR + 1);

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1; walks rcon 01,02,04,...
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte in, one byte out.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input byte.
module aes_sbox (
    input  logic [7:0] val,
    output logic [7:0] sub
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign sub = SBOX[val];

endmodule

// File: rtl/aes192_dec_key_sched.sv
// AES-192 key expansion (one word per clock) serving round keys in decrypt order.
// Latency: 46 cycles start-to-ready; rd_key registered one cycle after rd_round.
// Backpressure: none; a start during expansion is dropped, reads return 0 until ready.
module aes192_dec_key_sched #(
    parameter int NK = aes192_pkg::NK,
    parameter int NR = aes192_pkg::NR,
    parameter int NW = aes192_pkg::NW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [191:0] key_in,
    output logic         busy,
    output logic         ready,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);

    import aes192_pkg::*;

    state_t     state;
    state_t     state_nxt;
    logic       accept;

    word_t      w [NW];
    logic [5:0] idx;
    logic [2:0] phase;
    logic [7:0] rcon;

    word_t      prev;
    word_t      rot;
    word_t      sub;
    word_t      temp;

    logic [3:0] k;
    logic [5:0] base;

    // Next state and status outputs; busy/ready depend only on the state register.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                busy = 1'b1;
                if (idx == 6'(NW - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Word index, wrapping mod-NK phase and round constant.
    always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
            idx   <= 6'(NK);
            phase <= 3'd0;
            rcon  <= 8'h01;
        end else if (state == EXPAND) begin
            idx   <= idx + 6'd1;
            phase <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
            if (phase == 3'd0) begin
                rcon <= xtime(rcon);
            end
        end
    end

    // Temp word: RotWord/SubWord/Rcon applied at the start of every NK-word group.
    assign prev = w[idx - 6'd1];
    assign rot  = {prev[23:0], prev[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .val (rot[8*b +: 8]),
            .sub (sub[8*b +: 8])
        );
    end

    assign temp = (phase == 3'd0) ? (sub ^ {rcon, 24'h0}) : prev;

    // Word store: cipher key on accept, then one expanded word per EXPAND cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < NK; j++) begin
                w[j] <= key_in[32*(NK-1-j) +: 32];
            end
        end else if (state == EXPAND) begin
            w[idx] <= w[idx - 6'(NK)] ^ temp;
        end
    end

    // Decrypt round r uses expansion key NR-r; zero whenever the store is not valid.
    assign k    = 4'(NR) - rd_round;
    assign base = {k, 2'b00};

    // Registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_key <= '0;
        end else if (ready && (rd_round <= 4'(NR))) begin
            rd_key <= {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
        end else begin
            rd_key <= '0;
        end
    end

endmodule
